// File: rtl/sram32x2_pkg.sv
// Shared types and constants for the 32x2 SRAM sequencer/arbiter.
package sram32x2_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 2;
    localparam int WORDS  = 32;

    typedef enum logic [3:0] {
        INIT_SETUP = 4'd0,
        INIT_PULSE = 4'd1,
        INIT_HOLD  = 4'd2,
        IDLE       = 4'd3,
        RD_WAIT    = 4'd4,
        RD_LATCH   = 4'd5,
        WR_SETUP   = 4'd6,
        WR_PULSE   = 4'd7,
        WR_HOLD    = 4'd8,
        ACK        = 4'd9
    } state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] wmask;
    } req_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; index 0 is port A, index 1 is port B.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic prio_b;

    // Grant selection: a lone request wins, a tie goes to the favoured side.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_b ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // After every grant the side that did not win becomes favoured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_b <= 1'b0;
        end else if (update) begin
            prio_b <= grant[0];
        end else begin
            prio_b <= prio_b;
        end
    end

endmodule

// File: rtl/sram32x2_ctrl_chk.sv
// Property checks for the SRAM sequencer: legal timing parameters and sane control.
module sram32x2_ctrl_chk #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 2
) (
    input logic       clk,
    input logic       reset,
    input logic [1:0] grant,
    input logic       ram_ce,
    input logic       ram_wclk_n
);

    localparam bit PARAMS_OK = (SETUP_CYC >= 1) && (PULSE_CYC >= 1) &&
                               (HOLD_CYC >= 1) && (RD_CYC >= 1);

    param_legal: assert property (@(posedge clk) PARAMS_OK)
        else $error("sram32x2_ctrl: timing parameters must all be >= 1");

    grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant))
        else $error("sram32x2_ctrl: arbiter granted both ports");

    wclk_needs_ce: assert property (@(posedge clk) disable iff (reset) !ram_wclk_n |-> ram_ce)
        else $error("sram32x2_ctrl: write clock low without chip enable");

endmodule

// File: rtl/sram32x2_ctrl.sv
// Sequencer/arbiter for a 32x2 bipolar SRAM: clears the array after reset, then
// serves one read or masked write at a time from two round-robin requesters.
module sram32x2_ctrl
    import sram32x2_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int RD_CYC    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic [DATA_W-1:0] a_wmask,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    input  logic [DATA_W-1:0] b_wmask,
    output logic              b_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_a,
    output logic [DATA_W-1:0] ram_i,
    output logic              ram_ce,
    output logic [1:0]        ram_we_n,
    output logic              ram_wclk_n,
    output logic              ram_latch_n,
    input  logic [DATA_W-1:0] ram_d
);

    localparam int MAX_CYC = max4(SETUP_CYC, PULSE_CYC, HOLD_CYC, RD_CYC);
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0]     CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [CW-1:0]     S_LD      = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0]     P_LD      = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]     H_LD      = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]     R_LD      = CW'(RD_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [ADDR_W-1:0] init_addr;
    req_t              cur;
    logic              winner_b;

    logic [1:0] req_vec;
    logic [1:0] grant;
    logic       arb_update;
    req_t       a_pkt;
    req_t       b_pkt;
    req_t       sel;

    assign req_vec    = {b_req, a_req};
    assign arb_update = (state == IDLE) && (req_vec != 2'b00);

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_vec),
        .update (arb_update),
        .grant  (grant)
    );

    sram32x2_ctrl_chk #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .RD_CYC    (RD_CYC)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .grant      (grant),
        .ram_ce     (ram_ce),
        .ram_wclk_n (ram_wclk_n)
    );

    // Pack both requests and pick the granted one.
    always_comb begin
        a_pkt = {a_we, a_addr, a_wdata, a_wmask};
        b_pkt = {b_we, b_addr, b_wdata, b_wmask};
        if (grant[1]) begin
            sel = b_pkt;
        end else begin
            sel = a_pkt;
        end
    end

    // Main sequencer; every RAM pin is registered and only moves outside the pulse window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= INIT_SETUP;
            cnt         <= S_LD;
            init_addr   <= {ADDR_W{1'b0}};
            cur         <= '0;
            winner_b    <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            rdata       <= {DATA_W{1'b0}};
            busy        <= 1'b1;
            ram_a       <= {ADDR_W{1'b0}};
            ram_i       <= {DATA_W{1'b0}};
            ram_ce      <= 1'b0;
            ram_we_n    <= 2'b11;
            ram_wclk_n  <= 1'b1;
            ram_latch_n <= 1'b1;
        end else begin
            case (state)
                INIT_SETUP: begin
                    ram_ce <= 1'b1;
                    ram_a  <= init_addr;
                    ram_i  <= {DATA_W{1'b0}};
                    if (cnt == CNT_ZERO) begin
                        state      <= INIT_PULSE;
                        cnt        <= P_LD;
                        ram_we_n   <= 2'b00;
                        ram_wclk_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                INIT_PULSE: begin
                    if (cnt == CNT_ZERO) begin
                        state      <= INIT_HOLD;
                        cnt        <= H_LD;
                        ram_we_n   <= 2'b11;
                        ram_wclk_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                INIT_HOLD: begin
                    if (cnt != CNT_ZERO) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (init_addr == LAST_ADDR) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        ram_ce <= 1'b0;
                    end else begin
                        state     <= INIT_SETUP;
                        cnt       <= S_LD;
                        init_addr <= init_addr + 5'd1;
                        ram_a     <= init_addr + 5'd1;
                    end
                end
                IDLE: begin
                    if (req_vec != 2'b00) begin
                        cur      <= sel;
                        winner_b <= grant[1];
                        busy     <= 1'b1;
                        ram_ce   <= 1'b1;
                        ram_a    <= sel.addr;
                        if (sel.we) begin
                            ram_i <= sel.wdata;
                            state <= WR_SETUP;
                            cnt   <= S_LD;
                        end else begin
                            state <= RD_WAIT;
                            cnt   <= R_LD;
                        end
                    end else begin
                        busy   <= 1'b0;
                        ram_ce <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    ram_a <= cur.addr;
                    if (cnt == CNT_ZERO) begin
                        state       <= RD_LATCH;
                        ram_latch_n <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RD_LATCH: begin
                    rdata       <= ram_d;
                    ram_latch_n <= 1'b1;
                    ram_ce      <= 1'b0;
                    a_ack       <= ~winner_b;
                    b_ack       <= winner_b;
                    state       <= ACK;
                end
                WR_SETUP: begin
                    ram_a <= cur.addr;
                    ram_i <= cur.wdata;
                    if (cnt == CNT_ZERO) begin
                        state      <= WR_PULSE;
                        cnt        <= P_LD;
                        ram_we_n   <= ~cur.wmask;
                        ram_wclk_n <= (cur.wmask == 2'b00);
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_PULSE: begin
                    if (cnt == CNT_ZERO) begin
                        state      <= WR_HOLD;
                        cnt        <= H_LD;
                        ram_we_n   <= 2'b11;
                        ram_wclk_n <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WR_HOLD: begin
                    if (cnt == CNT_ZERO) begin
                        state  <= ACK;
                        ram_ce <= 1'b0;
                        a_ack  <= ~winner_b;
                        b_ack  <= winner_b;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ACK: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state      <= INIT_SETUP;
                    cnt        <= S_LD;
                    init_addr  <= {ADDR_W{1'b0}};
                    busy       <= 1'b1;
                    ram_ce     <= 1'b0;
                    ram_we_n   <= 2'b11;
                    ram_wclk_n <= 1'b1;
                end
            endcase
        end
    end

endmodule
